// File: rtl/axi_master_burst_read_axi3_pkg.sv
// Shared types and constants for the framebuffer burst read master.
// State encodings double as the debug state output.
package axi_master_burst_read_axi3_pkg;

    typedef enum logic [3:0] {
        ST_IDLE = 4'd0,
        ST_ADDR = 4'd1,
        ST_DATA = 4'd2,
        ST_DONE = 4'd3
    } state_e;

    localparam logic [31:0] LINE_STRIDE     = 32'd800;
    localparam int          MAX_BURST       = 16;
    localparam logic [1:0]  AXI_BURST_INCR  = 2'b01;
    localparam logic [1:0]  AXI_RESP_OKAY   = 2'b00;
    localparam logic [3:0]  ARCACHE_DEFAULT = 4'b0011;

endpackage

// File: rtl/axi_master_burst_read_axi3_burst_len_calc.sv
// Burst sizing: min(16, pixels left, bytes to the next 4 KB boundary).
// Pure combinational so the write master can share it.
module burst_len_calc
    import axi_master_burst_read_axi3_pkg::*;
(
    input  logic [31:0] addr_i,
    input  logic [10:0] width_i,
    output logic [4:0]  len_o,
    output logic [31:0] next_addr_o
);

    logic [12:0] to_4k;
    logic [12:0] len_w;
    logic        unused_hi;

    always_comb begin
        to_4k = 13'd4096 - {1'b0, addr_i[11:0]};
        len_w = 13'(MAX_BURST);
        if ({2'b00, width_i} < len_w) len_w = {2'b00, width_i};
        if (to_4k < len_w) len_w = to_4k;
        len_o       = len_w[4:0];
        next_addr_o = addr_i + {19'd0, len_w};
    end

    assign unused_hi = ^len_w[12:5];

endmodule

// File: rtl/axi_master_burst_read_axi3.sv
// AXI3 burst read master: streams a rectangular 8bpp region out of the
// 800-byte-stride framebuffer, one pixel per R beat.
module axi_master_burst_read_axi3
    import axi_master_burst_read_axi3_pkg::*;
(
    input  logic        clk,
    input  logic        reset,
    input  logic [31:0] framebuffer_baseaddr,
    input  logic [10:0] pixel_x,
    input  logic [10:0] pixel_y,
    input  logic [10:0] width,
    input  logic [10:0] height,
    input  logic        start,
    output logic [7:0]  pixel_data,
    output logic        pixel_valid,
    input  logic        pixel_ready,
    output logic        pixel_eol,
    output logic        pixel_last,
    output logic        busy,
    output logic        done,
    output logic        rresp_err,
    output logic [3:0]  state,
    output logic [31:0] M00_AXI_araddr,
    output logic [3:0]  M00_AXI_arlen,
    output logic [2:0]  M00_AXI_arsize,
    output logic [1:0]  M00_AXI_arburst,
    output logic [1:0]  M00_AXI_arlock,
    output logic [3:0]  M00_AXI_arcache,
    output logic [2:0]  M00_AXI_arprot,
    output logic [3:0]  M00_AXI_arqos,
    output logic [3:0]  M00_AXI_aruser,
    output logic        M00_AXI_arvalid,
    input  logic        M00_AXI_arready,
    input  logic [31:0] M00_AXI_rdata,
    input  logic [1:0]  M00_AXI_rresp,
    input  logic        M00_AXI_rlast,
    input  logic        M00_AXI_rvalid,
    output logic        M00_AXI_rready,
    output logic [31:0] M00_AXI_awaddr,
    output logic [3:0]  M00_AXI_awlen,
    output logic [2:0]  M00_AXI_awsize,
    output logic [1:0]  M00_AXI_awburst,
    output logic [1:0]  M00_AXI_awlock,
    output logic [3:0]  M00_AXI_awcache,
    output logic [2:0]  M00_AXI_awprot,
    output logic [3:0]  M00_AXI_awqos,
    output logic [3:0]  M00_AXI_awuser,
    output logic        M00_AXI_awvalid,
    input  logic        M00_AXI_awready,
    output logic [31:0] M00_AXI_wdata,
    output logic [3:0]  M00_AXI_wstrb,
    output logic        M00_AXI_wlast,
    output logic        M00_AXI_wvalid,
    input  logic        M00_AXI_wready,
    input  logic [1:0]  M00_AXI_bresp,
    input  logic        M00_AXI_bvalid,
    output logic        M00_AXI_bready
);

    state_e      state_q, state_d;
    logic [31:0] row_addr_q, cur_addr_q, araddr_q;
    logic [10:0] width_max_q, width_left_q, height_left_q;
    logic [3:0]  arlen_q, beat_cnt_q;
    logic [1:0]  lane_q;
    logic        rresp_err_q;

    logic [31:0] y32, row_start, calc_addr, calc_next;
    logic [10:0] calc_w;
    logic [4:0]  len, len_m1;
    logic        start_ok, empty, beat, burst_end, issue;
    logic        unused_ok;

    assign y32       = {21'd0, pixel_y};
    assign row_start = framebuffer_baseaddr + (y32 << 9) + (y32 << 8)
                     + (y32 << 5) + {21'd0, pixel_x};

    assign start_ok  = (state_q == ST_IDLE) && start;
    assign empty     = (width == '0) || (height == '0);
    assign beat      = (state_q == ST_DATA) && M00_AXI_rvalid && pixel_ready;
    assign burst_end = beat && M00_AXI_rlast;
    assign issue     = (start_ok && !empty)
                     || (burst_end && ((width_left_q != '0) || (height_left_q > 11'd1)));

    // Next burst comes from the new region, the rest of this row, or the next row.
    always_comb begin
        calc_addr = cur_addr_q;
        calc_w    = width_left_q;
        if (state_q == ST_IDLE) begin
            calc_addr = row_start;
            calc_w    = width;
        end else if (width_left_q == '0) begin
            calc_addr = row_addr_q + LINE_STRIDE;
            calc_w    = width_max_q;
        end
    end

    burst_len_calc u_len (
        .addr_i      (calc_addr),
        .width_i     (calc_w),
        .len_o       (len),
        .next_addr_o (calc_next)
    );

    assign len_m1 = len - 5'd1;

    always_ff @(posedge clk) begin
        if (reset) state_q <= ST_IDLE;
        else       state_q <= state_d;
    end

    always_comb begin
        state_d = state_q;
        unique case (state_q)
            ST_IDLE: if (start) state_d = empty ? ST_DONE : ST_ADDR;
            ST_ADDR: if (M00_AXI_arready) state_d = ST_DATA;
            ST_DATA: if (burst_end) state_d = issue ? ST_ADDR : ST_DONE;
            ST_DONE: state_d = ST_IDLE;
            default: state_d = ST_IDLE;
        endcase
    end

    always_comb begin
        M00_AXI_arvalid = (state_q == ST_ADDR);
        M00_AXI_rready  = (state_q == ST_DATA) && pixel_ready;
        pixel_valid     = (state_q == ST_DATA) && M00_AXI_rvalid;
        pixel_eol       = pixel_valid && M00_AXI_rlast && (width_left_q == '0);
        pixel_last      = pixel_eol && (height_left_q <= 11'd1);
        busy            = (state_q != ST_IDLE);
        done            = (state_q == ST_DONE);
    end

    always_ff @(posedge clk) begin
        if (reset) begin
            row_addr_q    <= '0;
            cur_addr_q    <= '0;
            araddr_q      <= '0;
            width_max_q   <= '0;
            width_left_q  <= '0;
            height_left_q <= '0;
            arlen_q       <= '0;
            beat_cnt_q    <= '0;
            lane_q        <= '0;
            rresp_err_q   <= 1'b0;
        end else begin
            if (start_ok) begin
                rresp_err_q   <= 1'b0;
                row_addr_q    <= row_start;
                width_max_q   <= width;
                height_left_q <= height;
            end
            if (beat) begin
                lane_q     <= lane_q + 2'd1;
                beat_cnt_q <= beat_cnt_q + 4'd1;
                if (M00_AXI_rresp != AXI_RESP_OKAY) rresp_err_q <= 1'b1;
                // rlast ends the burst regardless; a short/long burst is flagged
                if (M00_AXI_rlast && (beat_cnt_q != arlen_q)) rresp_err_q <= 1'b1;
            end
            if (burst_end && (width_left_q == '0) && (height_left_q > 11'd1)) begin
                row_addr_q    <= row_addr_q + LINE_STRIDE;
                height_left_q <= height_left_q - 11'd1;
            end
            if (issue) begin
                araddr_q     <= calc_addr;
                arlen_q      <= len_m1[3:0];
                cur_addr_q   <= calc_next;
                width_left_q <= calc_w - {6'd0, len};
                lane_q       <= calc_addr[1:0];
                beat_cnt_q   <= '0;
            end
        end
    end

    assign pixel_data = M00_AXI_rdata[{lane_q, 3'b000} +: 8];
    assign rresp_err  = rresp_err_q;
    assign state      = state_q;

    assign M00_AXI_araddr  = araddr_q;
    assign M00_AXI_arlen   = arlen_q;
    assign M00_AXI_arsize  = 3'd0;
    assign M00_AXI_arburst = AXI_BURST_INCR;
    assign M00_AXI_arlock  = '0;
    assign M00_AXI_arcache = ARCACHE_DEFAULT;
    assign M00_AXI_arprot  = '0;
    assign M00_AXI_arqos   = '0;
    assign M00_AXI_aruser  = '0;

    assign M00_AXI_awaddr  = '0;
    assign M00_AXI_awlen   = '0;
    assign M00_AXI_awsize  = '0;
    assign M00_AXI_awburst = '0;
    assign M00_AXI_awlock  = '0;
    assign M00_AXI_awcache = '0;
    assign M00_AXI_awprot  = '0;
    assign M00_AXI_awqos   = '0;
    assign M00_AXI_awuser  = '0;
    assign M00_AXI_awvalid = 1'b0;
    assign M00_AXI_wdata   = '0;
    assign M00_AXI_wstrb   = '0;
    assign M00_AXI_wlast   = 1'b0;
    assign M00_AXI_wvalid  = 1'b0;
    assign M00_AXI_bready  = 1'b0;

    assign unused_ok = ^{M00_AXI_awready, M00_AXI_wready, M00_AXI_bresp,
                         M00_AXI_bvalid, len_m1[4]};

endmodule

// File: tb/tb_axi_master_burst_read_axi3.sv
// Bench for the framebuffer burst read master: AXI slave model over a
// synthetic memory, pixel/AR scoreboards and a vector table of regions.
module tb_axi_master_burst_read_axi3;

    typedef struct {
        logic [31:0] base;
        int x, y, w, h;
        bit rnd;
        int ardly;
        int errb;
        int ars;
        int pix;
        bit err;
    } vec_t;

    typedef struct {
        logic [7:0] d;
        logic eol;
        logic last;
    } px_t;

    typedef struct {
        logic [31:0] a;
        logic [3:0] len;
    } ar_t;

    logic        clk, reset, start;
    logic [31:0] base;
    logic [10:0] px, py, pw, ph;
    logic [7:0]  pixel_data;
    logic        pixel_valid, pixel_ready, pixel_eol, pixel_last;
    logic        busy, done, rresp_err;
    logic [3:0]  state;
    logic [31:0] araddr;
    logic [3:0]  arlen;
    logic [2:0]  arsize, arprot;
    logic [1:0]  arburst, arlock;
    logic [3:0]  arcache, arqos, aruser;
    logic        arvalid, arready;
    logic [31:0] rdata;
    logic [1:0]  rresp;
    logic        rlast, rvalid, rready;
    logic [31:0] awaddr, wdata;
    logic [3:0]  awlen, awcache, awqos, awuser, wstrb;
    logic [2:0]  awsize, awprot;
    logic [1:0]  awburst, awlock;
    logic        awvalid, wlast, wvalid, bready;

    int tests = 0;
    int failed = 0;
    int cyc = 0;
    int done_cnt = 0, done_cyc = 0;
    int pix_cnt = 0, ar_cnt = 0, beat_g = 0;
    int first_pix_cyc = -1, last_pix_cyc = 0;
    bit rnd_g = 0;
    int ardly_g = 0, errb_g = -1;

    px_t exp_px[$];
    ar_t exp_ar[$];
    ar_t sl_q[$];

    axi_master_burst_read_axi3 dut (
        .clk(clk), .reset(reset),
        .framebuffer_baseaddr(base),
        .pixel_x(px), .pixel_y(py), .width(pw), .height(ph),
        .start(start),
        .pixel_data(pixel_data), .pixel_valid(pixel_valid),
        .pixel_ready(pixel_ready), .pixel_eol(pixel_eol),
        .pixel_last(pixel_last), .busy(busy), .done(done),
        .rresp_err(rresp_err), .state(state),
        .M00_AXI_araddr(araddr), .M00_AXI_arlen(arlen),
        .M00_AXI_arsize(arsize), .M00_AXI_arburst(arburst),
        .M00_AXI_arlock(arlock), .M00_AXI_arcache(arcache),
        .M00_AXI_arprot(arprot), .M00_AXI_arqos(arqos),
        .M00_AXI_aruser(aruser), .M00_AXI_arvalid(arvalid),
        .M00_AXI_arready(arready),
        .M00_AXI_rdata(rdata), .M00_AXI_rresp(rresp),
        .M00_AXI_rlast(rlast), .M00_AXI_rvalid(rvalid),
        .M00_AXI_rready(rready),
        .M00_AXI_awaddr(awaddr), .M00_AXI_awlen(awlen),
        .M00_AXI_awsize(awsize), .M00_AXI_awburst(awburst),
        .M00_AXI_awlock(awlock), .M00_AXI_awcache(awcache),
        .M00_AXI_awprot(awprot), .M00_AXI_awqos(awqos),
        .M00_AXI_awuser(awuser), .M00_AXI_awvalid(awvalid),
        .M00_AXI_awready(1'b0),
        .M00_AXI_wdata(wdata), .M00_AXI_wstrb(wstrb),
        .M00_AXI_wlast(wlast), .M00_AXI_wvalid(wvalid),
        .M00_AXI_wready(1'b0),
        .M00_AXI_bresp(2'b00), .M00_AXI_bvalid(1'b0),
        .M00_AXI_bready(bready)
    );

    initial begin
        clk = 0;
        forever #5 clk = ~clk;
    end

    initial forever begin
        @(posedge clk);
        cyc++;
    end

    initial begin
        #500000;
        $display("FAIL watchdog: simulation did not finish");
        $fatal(1, "watchdog");
    end

    function automatic logic [7:0] mem_b(input logic [31:0] a);
        return a[7:0] ^ a[15:8] ^ a[23:16] ^ 8'h5A;
    endfunction

    function automatic logic [31:0] mem_w(input logic [31:0] a);
        logic [31:0] b;
        b = {a[31:2], 2'b00};
        return {mem_b(b + 3), mem_b(b + 2), mem_b(b + 1), mem_b(b)};
    endfunction

    task automatic chk(input string n, input logic [63:0] act,
                       input logic [63:0] exp);
        tests++;
        if (act !== exp) begin
            failed++;
            $display("FAIL %s: got %0h expected %0h", n, act, exp);
        end
    endtask

    task automatic build_exp(input vec_t v);
        logic [31:0] ra, a;
        int rem, l, off;
        exp_px.delete();
        exp_ar.delete();
        for (int r = 0; r < v.h; r++) begin
            ra = v.base + 32'((v.y + r) * 800 + v.x);
            for (int c = 0; c < v.w; c++) begin
                a = ra + 32'(c);
                exp_px.push_back('{mem_b(a), c == v.w - 1,
                                   (c == v.w - 1) && (r == v.h - 1)});
            end
            a = ra;
            rem = v.w;
            while (rem > 0) begin
                off = 4096 - int'(a[11:0]);
                l = (rem < 16) ? rem : 16;
                if (off < l) l = off;
                exp_ar.push_back('{a, 4'(l - 1)});
                a += 32'(l);
                rem -= l;
            end
        end
    endtask

    // AXI slave, consumer and monitors; all decisions made at the negedge
    bit          ar_fire = 0, r_fire = 0, pix_fire = 0, hold_v = 0;
    logic [31:0] s_ara, hold_a;
    logic [3:0]  s_arl, hold_l;
    logic [7:0]  s_pd;
    logic        s_eol, s_last;
    int          s_cyc, rb = 0, ar_wait = 0;

    initial begin
        ar_t e;
        px_t p;
        logic [31:0] a;
        arready = 0; rvalid = 0; rdata = 0; rresp = 0; rlast = 0;
        pixel_ready = 0;
        forever begin
            @(negedge clk);
            if (ar_fire) begin
                tests++;
                if (exp_ar.size() == 0) begin
                    failed++;
                    $display("FAIL ar_extra: got %h/%0d expected none",
                             s_ara, s_arl);
                end else begin
                    e = exp_ar.pop_front();
                    if (e.a !== s_ara || e.len !== s_arl) begin
                        failed++;
                        $display("FAIL ar: got %h/%0d expected %h/%0d",
                                 s_ara, s_arl, e.a, e.len);
                    end
                end
                sl_q.push_back('{s_ara, s_arl});
                ar_cnt++;
                arready = 0;
                ar_wait = $urandom_range(0, ardly_g);
            end
            if (r_fire) begin
                rb++;
                beat_g++;
                if (sl_q.size() != 0 && rb > int'(sl_q[0].len)) begin
                    void'(sl_q.pop_front());
                    rb = 0;
                end
            end
            if (pix_fire) begin
                tests++;
                pix_cnt++;
                last_pix_cyc = s_cyc;
                if (pix_cnt == 1) first_pix_cyc = s_cyc;
                if (exp_px.size() == 0) begin
                    failed++;
                    $display("FAIL pixel_extra: got %h expected none", s_pd);
                end else begin
                    p = exp_px.pop_front();
                    if ({s_pd, s_eol, s_last} !== {p.d, p.eol, p.last}) begin
                        failed++;
                        $display("FAIL pixel: got %h/%b/%b expected %h/%b/%b",
                                 s_pd, s_eol, s_last, p.d, p.eol, p.last);
                    end
                end
            end
            if (arvalid && !arready) begin
                if (ar_wait == 0) arready = 1;
                else ar_wait--;
            end
            if (sl_q.size() == 0) rvalid = 0;
            else if (!rvalid || r_fire)
                rvalid = rnd_g ? ($urandom_range(0, 3) != 0) : 1'b1;
            if (sl_q.size() != 0) begin
                a = sl_q[0].a + 32'(rb);
                rdata = mem_w(a);
                rlast = (rb == int'(sl_q[0].len));
                rresp = (beat_g == errb_g) ? 2'b10 : 2'b00;
            end
            pixel_ready = rnd_g ? 1'($urandom_range(0, 1)) : 1'b1;
            #1;
            if (reset) begin
                sl_q.delete();
                rb = 0; rvalid = 0; arready = 0;
                ar_fire = 0; r_fire = 0; pix_fire = 0; hold_v = 0;
            end else begin
                if (hold_v && arvalid)
                    chk("ar_stable", {araddr, arlen}, {hold_a, hold_l});
                hold_v = arvalid && !arready;
                hold_a = araddr;
                hold_l = arlen;
                ar_fire = arvalid && arready;
                s_ara = araddr;
                s_arl = arlen;
                r_fire = rvalid && rready;
                pix_fire = pixel_valid && pixel_ready;
                s_pd = pixel_data;
                s_eol = pixel_eol;
                s_last = pixel_last;
                s_cyc = cyc;
                if (done) begin
                    done_cnt++;
                    done_cyc = cyc;
                end
            end
        end
    end

    task automatic chk_reset_outs(input string n);
        chk({n, "_outs"}, {arvalid, rready, pixel_valid, pixel_eol,
                           pixel_last, busy, done, rresp_err}, 0);
        chk({n, "_state"}, state, 0);
        chk({n, "_araddr"}, araddr, 0);
        chk({n, "_arlen"}, arlen, 0);
    endtask

    task automatic launch(input vec_t v);
        build_exp(v);
        rnd_g = v.rnd; ardly_g = v.ardly; errb_g = v.errb;
        pix_cnt = 0; ar_cnt = 0; beat_g = 0; first_pix_cyc = -1;
        @(negedge clk);
        base = v.base;
        px = 11'(v.x); py = 11'(v.y); pw = 11'(v.w); ph = 11'(v.h);
        start = 1;
    endtask

    task automatic run_vec(input vec_t v, input int idx);
        int d0, sc;
        string n;
        n = $sformatf("v%0d", idx);
        d0 = done_cnt;
        launch(v);
        sc = cyc;
        @(posedge clk);
        #1;
        chk({n, "_err_clr"}, rresp_err, 0);
        if (v.w == 0 || v.h == 0) begin
            chk({n, "_done_next"}, {done, state}, {1'b1, 4'd3});
        end else begin
            chk({n, "_ar_rise"}, {arvalid, busy, state}, {2'b11, 4'd1});
        end
        @(negedge clk);
        start = 0;
        base = $urandom; px = 11'($urandom); py = 11'($urandom);
        pw = 11'($urandom); ph = 11'($urandom);
        if (v.w != 0 && v.h != 0) begin
            @(negedge clk);
            start = 1;
            @(negedge clk);
            start = 0;
        end
        for (int i = 0; i < 4000 && done_cnt == d0; i++) @(negedge clk);
        chk({n, "_done_seen"}, done_cnt != d0, 1);
        chk({n, "_ar_count"}, ar_cnt, v.ars);
        chk({n, "_pix_count"}, pix_cnt, v.pix);
        chk({n, "_rresp_err"}, rresp_err, v.err);
        if (v.w == 0 || v.h == 0)
            chk({n, "_done_lat"}, done_cyc - sc, 1);
        else
            chk({n, "_done_lat"}, done_cyc - last_pix_cyc, 1);
        if (!v.rnd && v.ars == 1)
            chk({n, "_back2back"}, last_pix_cyc - first_pix_cyc, v.w - 1);
    endtask

    vec_t vecs[8];

    initial begin
        vec_t mid;
        vecs[0] = '{32'h1000_0000, 0, 0, 16, 1, 0, 0, -1, 1, 16, 0};
        vecs[1] = '{32'h1000_0000, 3, 2, 40, 2, 0, 0, -1, 6, 80, 0};
        vecs[2] = '{32'h1000_0FFA, 0, 0, 16, 1, 0, 0, -1, 2, 16, 0};
        vecs[3] = '{32'h2000_0100, 5, 7, 37, 3, 1, 5, -1, 9, 111, 0};
        vecs[4] = '{32'h4000_0F80, 0, 0, 200, 2, 1, 5, -1, 26, 400, 0};
        vecs[5] = '{32'h1000_0000, 1, 1, 20, 2, 1, 3, 7, 4, 40, 1};
        vecs[6] = '{32'h3000_0000, 100, 0, 8, 1, 0, 0, -1, 1, 8, 0};
        vecs[7] = '{32'h1000_0000, 0, 0, 0, 5, 0, 0, -1, 0, 0, 0};

        reset = 1; start = 0;
        base = 0; px = 0; py = 0; pw = 0; ph = 0;
        repeat (3) @(negedge clk);
        @(posedge clk);
        #1;
        chk_reset_outs("reset");
        @(negedge clk);
        reset = 0;

        for (int i = 0; i < 8; i++) run_vec(vecs[i], i);

        // height of zero also completes with no traffic
        mid = '{32'h1000_0000, 0, 0, 10, 0, 0, 0, -1, 0, 0, 0};
        run_vec(mid, 8);

        // reset in the middle of a data phase
        mid = vecs[1];
        launch(mid);
        @(negedge clk);
        start = 0;
        for (int i = 0; i < 2000 && pix_cnt < 5; i++) @(negedge clk);
        chk("mid_reached_data", pix_cnt >= 5, 1);
        reset = 1;
        @(posedge clk);
        #1;
        chk_reset_outs("mid_reset");
        @(negedge clk);
        reset = 0;
        exp_px.delete();
        exp_ar.delete();
        repeat (2) @(negedge clk);
        run_vec(vecs[0], 9);

        $display("[TB] %0d tests run, %0d failed", tests, failed);
        $finish;
    end

endmodule
